// File: rtl/goofy_alu_mc.sv
// goofy_alu_mc: parametrised multi-cycle ALU with two operand registers.
// Single-cycle ops retire on the accept edge. MUL (shift-add, one multiplier
// bit per clock) and SHL/SHR (one bit per clock) iterate in private working
// registers, so the visible result only changes when an op retires.
module goofy_alu_mc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         res,
    input  logic         a_we,
    input  logic         b_we,
    input  logic [W-1:0] a_d,
    input  logic [W-1:0] b_d,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o,
    input  logic         op_valid,
    input  logic [3:0]   op_code,
    output logic         op_ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] out,
    output logic [W-1:0] out_hi,
    output logic         flag_c,
    output logic         flag_z,
    output logic         flag_eq,
    output logic         flag_hlt
);

    localparam int SW = $clog2(W);
    localparam logic [SW-1:0] MUL_CNT = SW'(W - 1);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_ADC  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SBB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_CMP  = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_HLT  = 4'd13;
    localparam logic [3:0] OP_FCLR = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // Zero detect used by every op that writes the result.
    function automatic logic is_zero(input logic [W-1:0] v);
        return (v == {W{1'b0}});
    endfunction

    // Architectural state
    logic [W-1:0]    a_r, b_r;
    state_t          state_r, state_nx;
    logic [W-1:0]    out_r, out_nx;
    logic [W-1:0]    out_hi_r, out_hi_nx;
    logic            c_r, c_nx;
    logic            z_r, z_nx;
    logic            eq_r, eq_nx;
    logic            hlt_r, hlt_nx;
    logic            done_r, done_nx;
    logic            busy_r, busy_nx;
    logic            ready_r, ready_nx;

    // Iteration working registers (never visible on outputs)
    logic [2*W-1:0]  mcand_r, mcand_nx;
    logic [W-1:0]    mplier_r, mplier_nx;
    logic [2*W-1:0]  acc_r, acc_nx;
    logic [W-1:0]    sh_r, sh_nx;
    logic            sh_left_r, sh_left_nx;
    logic [SW-1:0]   cnt_r, cnt_nx;

    // Datapath helpers
    logic            accept_s;
    logic            exec_s;
    logic            cin_s;
    logic            bin_s;
    logic [W:0]      sum_s;
    logic [W:0]      diff_s;
    logic [2*W-1:0]  acc_add_s;
    logic [W-1:0]    sh_shift_s;
    logic            sh_bit_s;
    logic [SW-1:0]   amt_s;

    assign accept_s   = op_valid & ready_r;
    // While halted only FCLR may run; everything else is silently dropped.
    assign exec_s     = accept_s & (~hlt_r | (op_code == OP_FCLR));
    assign cin_s      = (op_code == OP_ADC) ? c_r : 1'b0;
    assign bin_s      = (op_code == OP_SBB) ? c_r : 1'b0;
    assign sum_s      = {1'b0, a_r} + {1'b0, b_r} + {{W{1'b0}}, cin_s};
    // Bit W of the W+1-bit difference is the borrow, i.e. A < B + cin.
    assign diff_s     = {1'b0, a_r} - {1'b0, b_r} - {{W{1'b0}}, bin_s};
    assign acc_add_s  = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    assign sh_shift_s = sh_left_r ? {sh_r[W-2:0], 1'b0} : {1'b0, sh_r[W-1:1]};
    assign sh_bit_s   = sh_left_r ? sh_r[W-1] : sh_r[0];
    assign amt_s      = b_r[SW-1:0];

    assign a_o      = a_r;
    assign b_o      = b_r;
    assign out      = out_r;
    assign out_hi   = out_hi_r;
    assign flag_c   = c_r;
    assign flag_z   = z_r;
    assign flag_eq  = eq_r;
    assign flag_hlt = hlt_r;
    assign done     = done_r;
    assign busy     = busy_r;
    assign op_ready = ready_r;

    // Operand registers: writable at any time, ops work on their own snapshot.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            a_r <= {W{1'b0}};
            b_r <= {W{1'b0}};
        end else begin
            if (a_we) begin
                a_r <= a_d;
            end
            if (b_we) begin
                b_r <= b_d;
            end
        end
    end

    // Next-state, result and flag logic for issue and iteration.
    always_comb begin
        state_nx   = state_r;
        out_nx     = out_r;
        out_hi_nx  = out_hi_r;
        c_nx       = c_r;
        z_nx       = z_r;
        eq_nx      = eq_r;
        hlt_nx     = hlt_r;
        done_nx    = 1'b0;
        mcand_nx   = mcand_r;
        mplier_nx  = mplier_r;
        acc_nx     = acc_r;
        sh_nx      = sh_r;
        sh_left_nx = sh_left_r;
        cnt_nx     = cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (exec_s) begin
                    case (op_code)
                        OP_ADD, OP_ADC: begin
                            out_nx  = sum_s[W-1:0];
                            c_nx    = sum_s[W];
                            z_nx    = is_zero(sum_s[W-1:0]);
                            done_nx = 1'b1;
                        end
                        OP_SUB, OP_SBB: begin
                            out_nx  = diff_s[W-1:0];
                            c_nx    = diff_s[W];
                            z_nx    = is_zero(diff_s[W-1:0]);
                            done_nx = 1'b1;
                        end
                        OP_AND: begin
                            out_nx  = a_r & b_r;
                            z_nx    = is_zero(a_r & b_r);
                            done_nx = 1'b1;
                        end
                        OP_OR: begin
                            out_nx  = a_r | b_r;
                            z_nx    = is_zero(a_r | b_r);
                            done_nx = 1'b1;
                        end
                        OP_XOR: begin
                            out_nx  = a_r ^ b_r;
                            z_nx    = is_zero(a_r ^ b_r);
                            done_nx = 1'b1;
                        end
                        OP_NOT: begin
                            out_nx  = ~a_r;
                            z_nx    = is_zero(~a_r);
                            done_nx = 1'b1;
                        end
                        OP_CMP: begin
                            eq_nx   = (a_r == b_r);
                            c_nx    = (a_r < b_r);
                            z_nx    = (a_r == b_r);
                            done_nx = 1'b1;
                        end
                        OP_SHL, OP_SHR: begin
                            if (amt_s == {SW{1'b0}}) begin
                                // Zero-distance shift is a plain copy; carry untouched.
                                out_nx  = a_r;
                                z_nx    = is_zero(a_r);
                                done_nx = 1'b1;
                            end else begin
                                sh_nx      = a_r;
                                sh_left_nx = (op_code == OP_SHL);
                                cnt_nx     = amt_s - {{(SW-1){1'b0}}, 1'b1};
                                state_nx   = ST_SHIFT;
                            end
                        end
                        OP_MUL: begin
                            mcand_nx  = {{W{1'b0}}, a_r};
                            mplier_nx = b_r;
                            acc_nx    = {(2*W){1'b0}};
                            cnt_nx    = MUL_CNT;
                            state_nx  = ST_MUL;
                        end
                        OP_HLT: begin
                            hlt_nx  = 1'b1;
                            done_nx = 1'b1;
                        end
                        OP_FCLR: begin
                            c_nx    = 1'b0;
                            z_nx    = 1'b0;
                            eq_nx   = 1'b0;
                            hlt_nx  = 1'b0;
                            done_nx = 1'b1;
                        end
                        default: begin
                            // NOP and the reserved code only signal completion.
                            done_nx = 1'b1;
                        end
                    endcase
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_nx    = acc_add_s;
                mcand_nx  = {mcand_r[2*W-2:0], 1'b0};
                mplier_nx = {1'b0, mplier_r[W-1:1]};
                if (cnt_r == {SW{1'b0}}) begin
                    out_nx    = acc_add_s[W-1:0];
                    out_hi_nx = acc_add_s[2*W-1:W];
                    c_nx      = ~is_zero(acc_add_s[2*W-1:W]);
                    z_nx      = is_zero(acc_add_s[W-1:0]);
                    done_nx   = 1'b1;
                    state_nx  = ST_IDLE;
                end else begin
                    cnt_nx = cnt_r - {{(SW-1){1'b0}}, 1'b1};
                end
            end
            ST_SHIFT: begin
                sh_nx = sh_shift_s;
                if (cnt_r == {SW{1'b0}}) begin
                    out_nx   = sh_shift_s;
                    c_nx     = sh_bit_s;
                    z_nx     = is_zero(sh_shift_s);
                    done_nx  = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt_r - {{(SW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx  = (state_nx != ST_IDLE);
        ready_nx = (state_nx == ST_IDLE);
    end

    // State, result, flag and handshake registers.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_r   <= ST_IDLE;
            out_r     <= {W{1'b0}};
            out_hi_r  <= {W{1'b0}};
            c_r       <= 1'b0;
            z_r       <= 1'b0;
            eq_r      <= 1'b0;
            hlt_r     <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            ready_r   <= 1'b1;
            mcand_r   <= {(2*W){1'b0}};
            mplier_r  <= {W{1'b0}};
            acc_r     <= {(2*W){1'b0}};
            sh_r      <= {W{1'b0}};
            sh_left_r <= 1'b0;
            cnt_r     <= {SW{1'b0}};
        end else begin
            state_r   <= state_nx;
            out_r     <= out_nx;
            out_hi_r  <= out_hi_nx;
            c_r       <= c_nx;
            z_r       <= z_nx;
            eq_r      <= eq_nx;
            hlt_r     <= hlt_nx;
            done_r    <= done_nx;
            busy_r    <= busy_nx;
            ready_r   <= ready_nx;
            mcand_r   <= mcand_nx;
            mplier_r  <= mplier_nx;
            acc_r     <= acc_nx;
            sh_r      <= sh_nx;
            sh_left_r <= sh_left_nx;
            cnt_r     <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_goofy_alu_mc.sv
// Scoreboard bench for goofy_alu_mc (W = 8): a behavioural model predicts each
// retirement (values and retire cycle); a monitor pops and compares on done.
module tb_goofy_alu_mc;

    localparam int W = 8;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_ADC  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SBB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_CMP  = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_SHR  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_HLT  = 4'd13;
    localparam logic [3:0] OP_FCLR = 4'd14;

    logic         clk = 1'b0;
    logic         res = 1'b0;
    logic         a_we = 1'b0, b_we = 1'b0;
    logic [W-1:0] a_d = '0, b_d = '0;
    logic [W-1:0] a_o, b_o;
    logic         op_valid = 1'b0;
    logic [3:0]   op_code = 4'd0;
    logic         op_ready, busy, done;
    logic [W-1:0] out, out_hi;
    logic         flag_c, flag_z, flag_eq, flag_hlt;

    goofy_alu_mc #(.W(W)) dut (
        .clk(clk), .res(res),
        .a_we(a_we), .b_we(b_we), .a_d(a_d), .b_d(b_d),
        .a_o(a_o), .b_o(b_o),
        .op_valid(op_valid), .op_code(op_code),
        .op_ready(op_ready), .busy(busy), .done(done),
        .out(out), .out_hi(out_hi),
        .flag_c(flag_c), .flag_z(flag_z), .flag_eq(flag_eq), .flag_hlt(flag_hlt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [W-1:0] m_a = '0, m_b = '0, m_out = '0, m_hi = '0;
    logic         m_c = 1'b0, m_z = 1'b0, m_eq = 1'b0, m_hlt = 1'b0;

    typedef struct {
        logic [W-1:0] out;
        logic [W-1:0] hi;
        logic         c, z, eq, hlt;
        int           cyc;
    } exp_t;
    exp_t scb[$];

    task automatic model_exec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              output bit push, output int lat);
        int s;
        int ia;
        int ib;
        int amt;
        ia = int'(a);
        ib = int'(b);
        push = 1'b1;
        lat = 0;
        if (m_hlt && op != OP_FCLR) begin
            push = 1'b0;
        end else begin
            case (op)
                OP_ADD, OP_ADC: begin
                    s = ia + ib + ((op == OP_ADC) ? int'(m_c) : 0);
                    m_out = W'(s);
                    m_c = (s >= (1 << W));
                    m_z = (m_out == 0);
                end
                OP_SUB, OP_SBB: begin
                    s = ia - ib - ((op == OP_SBB) ? int'(m_c) : 0);
                    m_out = W'(s);
                    m_c = (s < 0);
                    m_z = (m_out == 0);
                end
                OP_AND: begin m_out = a & b; m_z = (m_out == 0); end
                OP_OR:  begin m_out = a | b; m_z = (m_out == 0); end
                OP_XOR: begin m_out = a ^ b; m_z = (m_out == 0); end
                OP_NOT: begin m_out = ~a;    m_z = (m_out == 0); end
                OP_CMP: begin m_eq = (a == b); m_c = (ia < ib); m_z = (a == b); end
                OP_SHL, OP_SHR: begin
                    amt = ib % W;
                    if (amt == 0) begin
                        m_out = a;
                    end else if (op == OP_SHL) begin
                        m_c = a[W-amt];
                        m_out = a << amt;
                        lat = amt;
                    end else begin
                        m_c = a[amt-1];
                        m_out = a >> amt;
                        lat = amt;
                    end
                    m_z = (m_out == 0);
                end
                OP_MUL: begin
                    s = ia * ib;
                    m_out = W'(s);
                    m_hi = W'(s >> W);
                    m_c = (m_hi != 0);
                    m_z = (m_out == 0);
                    lat = W;
                end
                OP_HLT:  m_hlt = 1'b1;
                OP_FCLR: begin m_c = 1'b0; m_z = 1'b0; m_eq = 1'b0; m_hlt = 1'b0; end
                default: ;
            endcase
        end
    endtask

    task automatic push_exp(input int lat);
        exp_t e;
        e.out = m_out; e.hi = m_hi; e.c = m_c; e.z = m_z; e.eq = m_eq; e.hlt = m_hlt;
        e.cyc = cyc + lat;
        scb.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest expected retirement.
    always @(negedge clk) begin
        exp_t e;
        if (res) begin
            check_val("busy_vs_ready", 32'(busy), 32'(!op_ready));
            if (done) begin
                if (scb.size() == 0) begin
                    check_val("spurious_done", 32'(done), 32'(0));
                end else begin
                    e = scb.pop_front();
                    check_val("out", 32'(out), 32'(e.out));
                    check_val("out_hi", 32'(out_hi), 32'(e.hi));
                    check_val("flag_c", 32'(flag_c), 32'(e.c));
                    check_val("flag_z", 32'(flag_z), 32'(e.z));
                    check_val("flag_eq", 32'(flag_eq), 32'(e.eq));
                    check_val("flag_hlt", 32'(flag_hlt), 32'(e.hlt));
                    check_val("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic do_write(input logic [W-1:0] a, input logic [W-1:0] b);
        a_d = a; b_d = b; a_we = 1'b1; b_we = 1'b1;
        @(posedge clk); #1;
        a_we = 1'b0; b_we = 1'b0;
        m_a = a; m_b = b;
    endtask

    task automatic issue_now(input logic [3:0] op);
        bit push;
        int lat;
        op_code = op;
        op_valid = 1'b1;
        model_exec(op, m_a, m_b, push, lat);
        @(posedge clk); #1;
        op_valid = 1'b0;
        if (push) push_exp(lat);
    endtask

    task automatic wait_ready();
        int i;
        i = 0;
        while (!op_ready && i < 40) begin
            @(posedge clk); #1;
            i++;
        end
        if (!op_ready) check_val("ready_timeout", 32'(op_ready), 32'(1));
    endtask

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        do_write(a, b);
        issue_now(op);
        wait_ready();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] b2b_ops [4];
        bit push;
        int lat;
        int nb;

        // Reset values
        #12;
        check_val("rst_out", 32'(out), 32'(0));
        check_val("rst_out_hi", 32'(out_hi), 32'(0));
        check_val("rst_a_o", 32'(a_o), 32'(0));
        check_val("rst_b_o", 32'(b_o), 32'(0));
        check_val("rst_flags", 32'({flag_c, flag_z, flag_eq, flag_hlt}), 32'(0));
        check_val("rst_busy", 32'(busy), 32'(0));
        check_val("rst_done", 32'(done), 32'(0));
        check_val("rst_ready", 32'(op_ready), 32'(1));
        res = 1'b1;
        @(posedge clk); #1;

        // Arithmetic chain
        do_op(OP_ADD, 8'hF0, 8'h20);
        do_op(OP_ADC, 8'h01, 8'h01);
        do_op(OP_SUB, 8'h10, 8'h20);
        do_op(OP_SBB, 8'h05, 8'h05);
        do_op(OP_CMP, 8'h42, 8'h42);

        // Back-to-back single-cycle issue: one done per clock
        b2b_ops = '{OP_AND, OP_OR, OP_XOR, OP_NOT};
        do_write(8'h0F, 8'h3C);
        for (int i = 0; i < 4; i++) begin
            op_code = b2b_ops[i];
            op_valid = 1'b1;
            model_exec(b2b_ops[i], m_a, m_b, push, lat);
            @(posedge clk); #1;
            if (push) push_exp(lat);
        end
        op_valid = 1'b0;
        @(posedge clk); #1;

        // MUL 0xFF*0xFF with op_valid held during busy
        do_write(8'hFF, 8'hFF);
        op_code = OP_MUL;
        op_valid = 1'b1;
        model_exec(OP_MUL, m_a, m_b, push, lat);
        @(posedge clk); #1;
        push_exp(lat);
        nb = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) break;
        end
        op_valid = 1'b0;
        check_val("mul_busy_cycles", 32'(nb), 32'(W));
        check_val("mul_ready_after", 32'(op_ready), 32'(1));
        @(posedge clk); #1;
        check_val("mul_no_extra_done", 32'(done), 32'(0));
        check_val("mul_no_extra_busy", 32'(busy), 32'(0));

        // Shifts
        do_op(OP_SHL, 8'h81, 8'h03);
        do_op(OP_SHR, 8'h81, 8'h01);
        do_op(OP_SHL, 8'h81, 8'h00);
        do_op(OP_NOP, 8'h00, 8'h00);

        // Operand write while MUL busy does not disturb it
        do_write(8'h03, 8'h05);
        issue_now(OP_MUL);
        @(posedge clk); #1;
        a_d = 8'h10; a_we = 1'b1;
        @(posedge clk); #1;
        a_we = 1'b0; m_a = 8'h10;
        wait_ready();
        check_val("a_o_after_busy_write", 32'(a_o), 32'(8'h10));

        // a_we on the accept edge: op sees the old A
        do_write(8'h07, 8'h02);
        op_code = OP_ADD;
        op_valid = 1'b1;
        a_d = 8'h30; a_we = 1'b1;
        model_exec(OP_ADD, m_a, m_b, push, lat);
        @(posedge clk); #1;
        op_valid = 1'b0; a_we = 1'b0; m_a = 8'h30;
        if (push) push_exp(lat);
        check_val("a_o_accept_write", 32'(a_o), 32'(8'h30));
        wait_ready();

        // Halt: ADD discarded, FCLR clears
        do_op(OP_HLT, 8'h00, 8'h00);
        do_write(8'h01, 8'h01);
        issue_now(OP_ADD);
        check_val("hlt_discard_done", 32'(done), 32'(0));
        check_val("hlt_flag", 32'(flag_hlt), 32'(1));
        check_val("hlt_ready", 32'(op_ready), 32'(1));
        wait_ready();
        do_op(OP_FCLR, 8'h00, 8'h00);

        // Reset in the middle of a MUL
        do_write(8'hAB, 8'hCD);
        issue_now(OP_MUL);
        repeat (3) @(posedge clk);
        #1;
        res = 1'b0;
        #1;
        check_val("midrst_out", 32'(out), 32'(0));
        check_val("midrst_out_hi", 32'(out_hi), 32'(0));
        check_val("midrst_flags", 32'({flag_c, flag_z, flag_eq, flag_hlt}), 32'(0));
        check_val("midrst_busy", 32'(busy), 32'(0));
        check_val("midrst_ready", 32'(op_ready), 32'(1));
        check_val("midrst_a_o", 32'(a_o), 32'(0));
        scb.delete();
        m_a = '0; m_b = '0; m_out = '0; m_hi = '0;
        m_c = 1'b0; m_z = 1'b0; m_eq = 1'b0; m_hlt = 1'b0;
        #2;
        res = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check_val("midrst_no_done", 32'(done), 32'(0));
        check_val("midrst_idle", 32'(busy), 32'(0));

        // Still operational after reset
        do_op(OP_ADD, 8'h01, 8'h02);
        do_op(OP_MUL, 8'h10, 8'h10);

        repeat (3) @(posedge clk);
        #1;
        check_val("scoreboard_empty", 32'(scb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
